// File: rtl/event_sequencer_if.sv
// Write-side bus of the event sequencer: a host offers timestamped events
// (delay, channel mask, packed values) with a valid/ready handshake.
interface event_sequencer_if #(
    parameter int unsigned NUM_INPUTS = 1,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned DELAY_W    = 32
);
    logic                         wr_valid;
    logic                         wr_ready;
    logic [DELAY_W-1:0]           wr_delay;
    logic [NUM_INPUTS-1:0]        wr_mask;
    logic [NUM_INPUTS*DATA_W-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_delay,
        output wr_mask,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_delay,
        input  wr_mask,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/event_sequencer.sv
// Input-event player for the RTLola monitor: queues (delay, mask, values) events in a
// FIFO and replays each as a single-cycle new_input strobe with matching input_flat data.
// Optional feature: define EVSEQ_ABS_TIME_EN to treat wr_delay as an absolute timestamp
// against a free-running counter, adding the now/late outputs.
module event_sequencer #(
    parameter int unsigned NUM_INPUTS = 1,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned DELAY_W    = 32,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    event_sequencer_if.slave             wr,
    output logic [NUM_INPUTS*DATA_W-1:0] input_flat,
    output logic [NUM_INPUTS-1:0]        new_input,
    output logic                         busy,
    output logic [$clog2(DEPTH):0]       fill_level,
    output logic [DELAY_W-1:0]           event_count
`ifdef EVSEQ_ABS_TIME_EN
    ,
    output logic [DELAY_W-1:0]           now,
    output logic                         late
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {StIdle, StWait, StFire} state_e;

    // FIFO storage and bookkeeping
    logic [DELAY_W-1:0]           mem_delay [DEPTH];
    logic [NUM_INPUTS-1:0]        mem_mask  [DEPTH];
    logic [NUM_INPUTS*DATA_W-1:0] mem_data  [DEPTH];
    logic [AW-1:0]                wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]                count_q, count_d;
    logic                         full, empty, push, pop;

    // Current event and FSM state
    state_e                       state_q, state_d;
    logic [DELAY_W-1:0]           cnt_q, cnt_d;
    logic [NUM_INPUTS-1:0]        mask_q, mask_d;
    logic [NUM_INPUTS*DATA_W-1:0] data_q, data_d;
    logic [DELAY_W-1:0]           event_count_q;
    logic                         fire_out;
    logic                         load;

`ifdef EVSEQ_ABS_TIME_EN
    logic [DELAY_W-1:0]           now_q;
    logic                         late_q, late_d;
`endif

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    // Ready comes from the registered occupancy only, so a pop never frees a slot same-cycle
    assign wr.wr_ready = ~full;
    assign push        = wr.wr_valid & ~full;

    // Event storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_delay[wr_ptr_q] <= wr.wr_delay;
            mem_mask[wr_ptr_q]  <= wr.wr_mask;
            mem_data[wr_ptr_q]  <= wr.wr_data;
        end
    end

    // Occupancy next-state
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Outputs only toggle while actually firing; en==0 masks a held FIRE
    assign fire_out = (state_q == StFire) && en;

    // FSM next-state: pop/load from IDLE or back-to-back from FIRE, count down in WAIT
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        data_d  = data_q;
        pop     = 1'b0;
        load    = 1'b0;
`ifdef EVSEQ_ABS_TIME_EN
        late_d  = late_q;
`endif
        if (en) begin
            unique case (state_q)
                StIdle: begin
                    load = ~empty;
                end
                StWait: begin
`ifdef EVSEQ_ABS_TIME_EN
                    // Leave one cycle early so FIRE coincides with now==stamp
                    if (now_q == cnt_q - DELAY_W'(1)) state_d = StFire;
`else
                    cnt_d = cnt_q - DELAY_W'(1);
                    if (cnt_q == DELAY_W'(1)) state_d = StFire;
`endif
                end
                StFire: begin
                    load = ~empty;
                    if (empty) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
        if (load) begin
            pop    = 1'b1;
            cnt_d  = mem_delay[rd_ptr_q];
            mask_d = mem_mask[rd_ptr_q];
            data_d = mem_data[rd_ptr_q];
`ifdef EVSEQ_ABS_TIME_EN
            // Stamps at or before now+1 fire next cycle; strictly past stamps are late
            if ({1'b0, mem_delay[rd_ptr_q]} <= ({1'b0, now_q} + (DELAY_W+1)'(1))) begin
                state_d = StFire;
            end else begin
                state_d = StWait;
            end
            if (mem_delay[rd_ptr_q] <= now_q) late_d = 1'b1;
`else
            state_d = (mem_delay[rd_ptr_q] == '0) ? StFire : StWait;
`endif
        end
    end

    // FSM, current-event and counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            mask_q        <= '0;
            data_q        <= '0;
            event_count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            if (fire_out && !(&event_count_q)) begin
                event_count_q <= event_count_q + DELAY_W'(1);
            end
        end
    end

`ifdef EVSEQ_ABS_TIME_EN
    // Free-running time base and sticky late flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            now_q  <= '0;
            late_q <= 1'b0;
        end else begin
            if (en) now_q <= now_q + DELAY_W'(1);
            late_q <= late_d;
        end
    end

    assign now  = now_q;
    assign late = late_q;
`endif

    // Per-channel output data: masked channels carry the value, others read 0
    always_comb begin
        input_flat = '0;
        for (int i = 0; i < int'(NUM_INPUTS); i++) begin
            if (fire_out && mask_q[i]) begin
                input_flat[i*DATA_W +: DATA_W] = data_q[i*DATA_W +: DATA_W];
            end
        end
    end

    assign new_input   = fire_out ? mask_q : '0;
    assign busy        = (state_q != StIdle) || !empty;
    assign fill_level  = count_q;
    assign event_count = event_count_q;

endmodule
